stack_op_master: RTL and testbench



---
 rtl/stack_op_master.sv | 193 +++++++++++++++++++
 tb/tb_stack_op_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_master.sv
// Operand-stack initiator: expands one stack command into single push/pop
// transactions, tracks depth locally and rejects commands that would under/overflow.
module stack_op_master #(
  parameter int STACKDATA = 32,
  parameter int STACKSIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [2:0]                     cmd_op,
  input  logic [STACKDATA-1:0]           cmd_imm,
  output logic [STACKDATA-1:0]           result,
  output logic                           result_valid,
  output logic                           err,
  output logic [$clog2(STACKSIZE+1)-1:0] depth,
  output logic                           push,
  output logic                           trigger,
  output logic [STACKDATA-1:0]           write_value,
  input  logic [STACKDATA-1:0]           read_value,
  input  logic                           done_out
);

  localparam int DW = $clog2(STACKSIZE+1);
  localparam logic [DW-1:0] FULL = DW'(STACKSIZE);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic [2:0]           op_q, op_d;
  logic [STACKDATA-1:0] imm_q, imm_d;
  logic [STACKDATA-1:0] a_q, a_d;
  logic [STACKDATA-1:0] b_q, b_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [STACKDATA-1:0] result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 err_q, err_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 trigger_q, trigger_d;
  logic                 push_q, push_d;
  logic [STACKDATA-1:0] write_value_q, write_value_d;
  logic                 check_ok;

  function automatic logic step_is_last(input logic [2:0] op, input logic [1:0] step);
    case (op)
      OP_PUSH, OP_POP:                step_is_last = (step == 2'd0);
      OP_DUP, OP_ADD, OP_SUB, OP_XOR: step_is_last = (step == 2'd2);
      default:                        step_is_last = (step == 2'd3);
    endcase
  endfunction

  function automatic logic step_is_push(input logic [2:0] op, input logic [1:0] step);
    case (op)
      OP_PUSH: step_is_push = 1'b1;
      OP_POP:  step_is_push = 1'b0;
      OP_DUP:  step_is_push = (step != 2'd0);
      default: step_is_push = (step >= 2'd2);
    endcase
  endfunction

  always_comb begin
    case (cmd_op)
      OP_PUSH: check_ok = (depth_q < FULL);
      OP_POP:  check_ok = (depth_q >= ONE);
      OP_DUP:  check_ok = (depth_q >= ONE) && (depth_q < FULL);
      default: check_ok = (depth_q >= TWO);
    endcase
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    op_d          = op_q;
    imm_d         = imm_q;
    a_d           = a_q;
    b_d           = b_q;
    depth_d       = depth_q;
    result_d      = result_q;
    err_d         = 1'b0;
    push_d        = push_q;
    write_value_d = write_value_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_op != OP_NOP) begin
          if (check_ok) begin
            op_d    = cmd_op;
            imm_d   = cmd_imm;
            step_d  = 2'd0;
            state_d = S_TRIG;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_TRIG: state_d = S_WAIT;
      S_WAIT: begin
        if (done_out) begin
          if (push_q) begin
            depth_d = depth_q + ONE;
          end else begin
            depth_d = depth_q - ONE;
            if (step_q == 2'd0) a_d = read_value;
            else                b_d = read_value;
          end
          if (step_is_last(op_q, step_q)) begin
            // The last transaction of every command carries its result value.
            result_d = push_q ? write_value_q : read_value;
            state_d  = S_DONE;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_TRIG;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Transaction fields are set up from next-state operands so a value
    // popped this cycle is already usable by the following push.
    if (state_d == S_TRIG) begin
      push_d = step_is_push(op_d, step_d);
      case (op_d)
        OP_PUSH: write_value_d = imm_d;
        OP_SWAP: write_value_d = (step_d == 2'd3) ? b_d : a_d;
        OP_ADD:  write_value_d = b_d + a_d;
        OP_SUB:  write_value_d = b_d - a_d;
        OP_XOR:  write_value_d = b_d ^ a_d;
        default: write_value_d = a_d;
      endcase
    end

    trigger_d      = (state_d == S_TRIG);
    result_valid_d = (state_d == S_DONE);
    cmd_ready_d    = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      step_q         <= 2'd0;
      op_q           <= OP_NOP;
      imm_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      depth_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      cmd_ready_q    <= 1'b1;
      trigger_q      <= 1'b0;
      push_q         <= 1'b0;
      write_value_q  <= '0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      op_q           <= op_d;
      imm_q          <= imm_d;
      a_q            <= a_d;
      b_q            <= b_d;
      depth_q        <= depth_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      cmd_ready_q    <= cmd_ready_d;
      trigger_q      <= trigger_d;
      push_q         <= push_d;
      write_value_q  <= write_value_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign depth        = depth_q;
  assign push         = push_q;
  assign trigger      = trigger_q;
  assign write_value  = write_value_q;

endmodule

// File: tb/tb_stack_op_master.sv
// Bench for stack_op_master: stack model answering 3 cycles after trigger,
// expected-event scoreboard drained by an independent monitor.
module tb_stack_op_master;

  localparam int K_PUSH = 0;
  localparam int K_POP  = 1;
  localparam int K_RES  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_imm = 32'd0;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic [4:0]  depth;
  logic        push;
  logic        trigger;
  logic [31:0] write_value;
  logic [31:0] read_value = 32'd0;
  logic        done_out = 1'b0;

  int   checks = 0;
  int   errors = 0;
  evt_t exp_q[$];

  logic [31:0] mstack[$];
  logic [31:0] pending_rv = 32'd0;
  int          cnt = 0;
  logic        withhold = 1'b0;

  stack_op_master #(.STACKDATA(32), .STACKSIZE(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .result(result), .result_valid(result_valid),
    .err(err), .depth(depth), .push(push), .trigger(trigger),
    .write_value(write_value), .read_value(read_value), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // Stack model: acts on trigger, raises done_out for one cycle 3 cycles later.
  always @(negedge clk) begin
    done_out = 1'b0;
    if (rst) begin
      mstack.delete();
      cnt = 0;
    end else if (trigger) begin
      if (push) mstack.push_back(write_value);
      else if (mstack.size() > 0) pending_rv = mstack.pop_back();
      else pending_rv = 32'd0;
      cnt = 3;
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0 && !withhold) begin
        done_out   = 1'b1;
        read_value = pending_rv;
      end
    end
  end

  task automatic check_evt(input int kind, input logic [31:0] val);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d value=%h required=none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || ((kind == K_PUSH || kind == K_RES) && e.val != val)) begin
        errors++;
        $display("FAIL event kind=%0d value=%h required kind=%0d value=%h", kind, val, e.kind, e.val);
      end else begin
        $display("event ok kind=%0d value=%h", kind, val);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (trigger)      check_evt(push ? K_PUSH : K_POP, write_value);
      if (result_valid) check_evt(K_RES, result);
      if (err)          check_evt(K_ERR, 32'd0);
    end
  end

  task automatic ex(input int kind, input logic [31:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("check ok %s = %h", name, act);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] imm);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL issue_timeout actual=busy required=ready");
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] imm);
    int n = 0;
    issue(op, imm);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL complete_timeout actual=busy required=ready");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_trigger", {31'd0, trigger}, 32'd0);
    chk("rst_depth", {27'd0, depth}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    // PUSH then POP
    ex(K_PUSH, 32'hcafe_babe); ex(K_RES, 32'hcafe_babe);
    run(3'd1, 32'hcafe_babe);
    chk("depth_after_push", {27'd0, depth}, 32'd1);
    ex(K_POP, 0); ex(K_RES, 32'hcafe_babe);
    run(3'd2, 32'd0);
    chk("depth_after_pop", {27'd0, depth}, 32'd0);

    // 7 - 5
    ex(K_PUSH, 32'd7); ex(K_RES, 32'd7); run(3'd1, 32'd7);
    ex(K_PUSH, 32'd5); ex(K_RES, 32'd5); run(3'd1, 32'd5);
    ex(K_POP, 0); ex(K_POP, 0); ex(K_PUSH, 32'd2); ex(K_RES, 32'd2);
    run(3'd6, 32'd0);
    chk("depth_after_sub", {27'd0, depth}, 32'd1);
    ex(K_POP, 0); ex(K_RES, 32'd2); run(3'd2, 32'd0);

    // wrapping ADD, then DUP
    ex(K_PUSH, 32'hffff_ffff); ex(K_RES, 32'hffff_ffff); run(3'd1, 32'hffff_ffff);
    ex(K_PUSH, 32'd1); ex(K_RES, 32'd1); run(3'd1, 32'd1);
    ex(K_POP, 0); ex(K_POP, 0); ex(K_PUSH, 32'd0); ex(K_RES, 32'd0);
    run(3'd5, 32'd0);
    ex(K_POP, 0); ex(K_PUSH, 32'd0); ex(K_PUSH, 32'd0); ex(K_RES, 32'd0);
    run(3'd3, 32'd0);
    chk("depth_after_dup", {27'd0, depth}, 32'd2);
    ex(K_POP, 0); ex(K_RES, 32'd0); run(3'd2, 32'd0);
    ex(K_POP, 0); ex(K_RES, 32'd0); run(3'd2, 32'd0);

    // SWAP
    ex(K_PUSH, 32'hdead_beef); ex(K_RES, 32'hdead_beef); run(3'd1, 32'hdead_beef);
    ex(K_PUSH, 32'hb105_f00d); ex(K_RES, 32'hb105_f00d); run(3'd1, 32'hb105_f00d);
    ex(K_POP, 0); ex(K_POP, 0); ex(K_PUSH, 32'hb105_f00d); ex(K_PUSH, 32'hdead_beef);
    ex(K_RES, 32'hdead_beef);
    run(3'd4, 32'd0);
    ex(K_POP, 0); ex(K_RES, 32'hdead_beef); run(3'd2, 32'd0);
    ex(K_POP, 0); ex(K_RES, 32'hb105_f00d); run(3'd2, 32'd0);
    chk("depth_after_swap_pops", {27'd0, depth}, 32'd0);

    // Rejections and NOP
    ex(K_ERR, 0); run(3'd2, 32'd0);
    chk("depth_pop_empty", {27'd0, depth}, 32'd0);
    run(3'd0, 32'd0);
    ex(K_PUSH, 32'd1); ex(K_RES, 32'd1); run(3'd1, 32'd1);
    ex(K_ERR, 0); run(3'd5, 32'd0);
    chk("depth_add_at_1", {27'd0, depth}, 32'd1);
    for (int i = 2; i <= 16; i++) begin
      ex(K_PUSH, 32'(i)); ex(K_RES, 32'(i)); run(3'd1, 32'(i));
    end
    chk("depth_full", {27'd0, depth}, 32'd16);
    ex(K_ERR, 0); run(3'd1, 32'h1234_5678);
    ex(K_ERR, 0); run(3'd3, 32'd0);
    chk("depth_push_at_full", {27'd0, depth}, 32'd16);
    ex(K_POP, 0); ex(K_POP, 0); ex(K_PUSH, 32'd31); ex(K_RES, 32'd31);
    run(3'd7, 32'd0);
    chk("depth_after_xor", {27'd0, depth}, 32'd15);

    // Reset during WAIT of an ADD with done_out withheld
    withhold = 1'b1;
    ex(K_POP, 0);
    issue(3'd5, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_trigger", {31'd0, trigger}, 32'd0);
    chk("midrst_depth", {27'd0, depth}, 32'd0);
    chk("midrst_push", {31'd0, push}, 32'd0);
    chk("midrst_write_value", write_value, 32'd0);
    chk("midrst_result_valid", {31'd0, result_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    withhold = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
